// File: rtl/router_pkt_reg.sv
// Router input-side packet register: frames header/payload/parity with its own
// FSM, forwards accepted bytes to the selected output FIFO through a single
// output register with backpressure, and flags address, length and checksum errors.
module router_pkt_reg #(
  parameter int DW        = 8,
  parameter int ADDR_W    = 2,
  parameter int NUM_PORTS = 3,
  parameter int CHK_MODE  = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              pkt_valid,
  input  logic [DW-1:0]     data_in,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic [DW-1:0]     dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_valid,
  output logic              parity_done,
  output logic              err_parity,
  output logic              err_len,
  output logic              err_addr
);

  localparam int LEN_W = DW - ADDR_W;
  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    DROP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [DW-1:0]    checksum;
  logic [DW-1:0]    checksum_next;
  logic             wait_low;
  logic             accept;
  logic             is_parity;
  logic             hdr_ok;
  logic             write_done;

  // Handshake, byte classification and next-state decode; a dropped packet
  // never writes, so DROP may keep consuming even while the FIFO is full.
  always_comb begin
    in_ready      = !(dout_valid && fifo_full);
    accept        = 1'b0;
    is_parity     = !pkt_valid || (count == len);
    hdr_ok        = ({1'b0, data_in[ADDR_W-1:0]} < PORT_LIMIT);
    write_done    = dout_valid && !fifo_full;
    checksum_next = (CHK_MODE == 0) ? (checksum ^ data_in) : (checksum + data_in);
    state_next    = state;
    case (state)
      IDLE: begin
        accept = pkt_valid && in_ready && !wait_low;
        if (accept) begin
          state_next = hdr_ok ? PAYLOAD : DROP;
        end
      end
      PAYLOAD: begin
        accept = in_ready;
        if (accept && is_parity) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        in_ready = 1'b1;
        accept   = 1'b1;
        if (is_parity) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Framing state register; both reset and packet abort return to IDLE.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Output register, header fields, length/checksum tracking and sticky errors;
  // an abort additionally arms wait_low so the rest of the aborted packet is skipped.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      dout        <= '0;
      dout_valid  <= 1'b0;
      dest        <= '0;
      dest_valid  <= 1'b0;
      parity_done <= 1'b0;
      err_parity  <= 1'b0;
      err_len     <= 1'b0;
      err_addr    <= 1'b0;
      checksum    <= '0;
      count       <= '0;
      len         <= '0;
      wait_low    <= !reset;
    end else begin
      parity_done <= 1'b0;
      if (write_done) begin
        dout_valid <= 1'b0;
      end
      if (state == IDLE && !pkt_valid) begin
        wait_low <= 1'b0;
      end
      if (accept) begin
        case (state)
          IDLE: begin
            dest       <= data_in[ADDR_W-1:0];
            len        <= data_in[DW-1:ADDR_W];
            count      <= '0;
            checksum   <= data_in;
            err_parity <= 1'b0;
            err_len    <= 1'b0;
            err_addr   <= !hdr_ok;
            dest_valid <= 1'b1;
            if (hdr_ok) begin
              dout       <= data_in;
              dout_valid <= 1'b1;
            end
          end
          PAYLOAD: begin
            dout       <= data_in;
            dout_valid <= 1'b1;
            if (is_parity) begin
              err_parity  <= (data_in != checksum);
              err_len     <= (count != len) || pkt_valid;
              parity_done <= 1'b1;
              dest_valid  <= 1'b0;
            end else begin
              count    <= count + LEN_W'(1);
              checksum <= checksum_next;
            end
          end
          DROP: begin
            if (is_parity) begin
              parity_done <= 1'b1;
              dest_valid  <= 1'b0;
            end else begin
              count <= count + LEN_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed bench for router_pkt_reg: one XOR-checksum and one additive-checksum
// instance share the same stimulus; expected values are hand-computed constants.
module tb_router_pkt_reg;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;

  logic       xor_in_ready, xor_dout_valid, xor_dest_valid, xor_parity_done;
  logic       xor_err_parity, xor_err_len, xor_err_addr;
  logic [7:0] xor_dout;
  logic [1:0] xor_dest;

  logic       add_in_ready, add_dout_valid, add_dest_valid, add_parity_done;
  logic       add_err_parity, add_err_len, add_err_addr;
  logic [7:0] add_dout;
  logic [1:0] add_dest;

  int compared   = 0;
  int mismatched = 0;
  int writes     = 0;
  int base       = 0;

  router_pkt_reg #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(0)) dut_xor (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .in_ready(xor_in_ready), .fifo_full(fifo_full),
    .dout(xor_dout), .dout_valid(xor_dout_valid), .dest(xor_dest),
    .dest_valid(xor_dest_valid), .parity_done(xor_parity_done),
    .err_parity(xor_err_parity), .err_len(xor_err_len), .err_addr(xor_err_addr)
  );

  router_pkt_reg #(.DW(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(1)) dut_add (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .in_ready(add_in_ready), .fifo_full(fifo_full),
    .dout(add_dout), .dout_valid(add_dout_valid), .dest(add_dest),
    .dest_valid(add_dest_valid), .parity_done(add_parity_done),
    .err_parity(add_err_parity), .err_len(add_err_len), .err_addr(add_err_addr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count completed FIFO writes of the XOR instance.
  always @(posedge clock) begin
    if (xor_dout_valid && !fifo_full) begin
      writes <= writes + 1;
    end
  end

  task automatic applyStimulus(input bit pv, input bit [7:0] d, input bit ff,
                               input bit sr, input bit rst);
    pkt_valid  = pv;
    data_in    = d;
    fifo_full  = ff;
    soft_reset = sr;
    reset      = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed packets.
  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); tick(); tick();
    checkOutput("rst_dout", 32'(xor_dout), 32'h00);
    checkOutput("rst_dout_valid", 32'(xor_dout_valid), 32'h0);
    checkOutput("rst_dest", 32'(xor_dest), 32'h0);
    checkOutput("rst_dest_valid", 32'(xor_dest_valid), 32'h0);
    checkOutput("rst_parity_done", 32'(xor_parity_done), 32'h0);
    checkOutput("rst_errs", 32'({xor_err_parity, xor_err_len, xor_err_addr}), 32'h0);
    checkOutput("rst_in_ready", 32'(xor_in_ready), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();

    $display("[TB] test 1: basic XOR packet");
    base = writes;
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_hdr_dout", 32'(xor_dout), 32'h0D);
    checkOutput("t1_hdr_dv", 32'(xor_dout_valid), 32'h1);
    checkOutput("t1_dest", 32'(xor_dest), 32'h1);
    checkOutput("t1_dest_valid", 32'(xor_dest_valid), 32'h1);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_p0_dout", 32'(xor_dout), 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_p1_dout", 32'(xor_dout), 32'h22);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_p2_dout", 32'(xor_dout), 32'h33);
    applyStimulus(1'b0, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_par_dout", 32'(xor_dout), 32'h0D);
    checkOutput("t1_par_dv", 32'(xor_dout_valid), 32'h1);
    checkOutput("t1_parity_done", 32'(xor_parity_done), 32'h1);
    checkOutput("t1_dest_valid_drop", 32'(xor_dest_valid), 32'h0);
    checkOutput("t1_errs", 32'({xor_err_parity, xor_err_len, xor_err_addr}), 32'h0);
    checkOutput("t1_add_err_parity", 32'(add_err_parity), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t1_idle_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t1_pulse_end", 32'(xor_parity_done), 32'h0);
    checkOutput("t1_writes", 32'(writes - base), 32'd5);

    $display("[TB] test 2: additive checksum and back-to-back header");
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 8'h73, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t2_add_err_parity_ok", 32'(add_err_parity), 32'h0);
    checkOutput("t2_xor_err_parity", 32'(xor_err_parity), 32'h1);
    checkOutput("t2_add_parity_done", 32'(add_parity_done), 32'h1);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t2_b2b_add_dout", 32'(add_dout), 32'h0D);
    checkOutput("t2_b2b_dest_valid", 32'(add_dest_valid), 32'h1);
    checkOutput("t2_b2b_xor_err_clear", 32'(xor_err_parity), 32'h0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 8'h74, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t2_add_err_parity_bad", 32'(add_err_parity), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick(); tick();
    checkOutput("t2_add_err_parity_held", 32'(add_err_parity), 32'h1);

    $display("[TB] test 3: FIFO backpressure");
    base = writes;
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t3_dout_22", 32'(xor_dout), 32'h22);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_in_ready_full0", 32'(xor_in_ready), 32'h0);
    checkOutput("t3_add_in_ready_full0", 32'(add_in_ready), 32'h0);
    tick();
    checkOutput("t3_hold0_dout", 32'(xor_dout), 32'h22);
    checkOutput("t3_hold0_dv", 32'(xor_dout_valid), 32'h1);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_in_ready_full1", 32'(xor_in_ready), 32'h0);
    tick();
    checkOutput("t3_hold1_dout", 32'(xor_dout), 32'h22);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_in_ready_free", 32'(xor_in_ready), 32'h1);
    tick();
    checkOutput("t3_dout_33", 32'(xor_dout), 32'h33);
    applyStimulus(1'b0, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t3_par_dout", 32'(xor_dout), 32'h0D);
    checkOutput("t3_err_parity", 32'(xor_err_parity), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t3_writes", 32'(writes - base), 32'd5);
    checkOutput("t3_idle_dv", 32'(xor_dout_valid), 32'h0);

    $display("[TB] test 4: bad destination");
    base = writes;
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t4_hdr_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t4_err_addr", 32'(xor_err_addr), 32'h1);
    checkOutput("t4_dest", 32'(xor_dest), 32'h3);
    checkOutput("t4_add_group", 32'({add_dout_valid, add_err_addr, add_dest, add_dest_valid}),
                32'b01111);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_drop_in_ready", 32'(xor_in_ready), 32'h1);
    tick();
    checkOutput("t4_drop_dv", 32'(xor_dout_valid), 32'h0);
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t4_parity_done", 32'(xor_parity_done), 32'h1);
    checkOutput("t4_par_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t4_dest_valid", 32'(xor_dest_valid), 32'h0);
    checkOutput("t4_err_addr_held", 32'(xor_err_addr), 32'h1);
    checkOutput("t4_no_writes", 32'(writes - base), 32'd0);
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t4_next_dv", 32'(xor_dout_valid), 32'h1);
    checkOutput("t4_next_dout", 32'(xor_dout), 32'h0D);
    checkOutput("t4_next_err_addr", 32'(xor_err_addr), 32'h0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t4_next_done", 32'({xor_parity_done, xor_err_parity, xor_err_len, xor_err_addr}),
                32'b1000);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();

    $display("[TB] test 5: length errors");
    base = writes;
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t5a_hdr_dout", 32'(xor_dout), 32'h09);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 8'h4D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t5a_err_len", 32'(xor_err_len), 32'h1);
    checkOutput("t5a_add_err_len", 32'(add_err_len), 32'h1);
    checkOutput("t5a_err_parity", 32'(xor_err_parity), 32'h0);
    checkOutput("t5a_parity_done", 32'(xor_parity_done), 32'h1);
    checkOutput("t5a_par_dout", 32'(xor_dout), 32'h4D);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t5a_writes", 32'(writes - base), 32'd3);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t5b_err_len_clear", 32'(xor_err_len), 32'h0);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t5b_parity_done", 32'(xor_parity_done), 32'h1);
    checkOutput("t5b_err_len", 32'(xor_err_len), 32'h1);
    checkOutput("t5b_err_parity", 32'(xor_err_parity), 32'h0);
    checkOutput("t5b_dest_valid", 32'(xor_dest_valid), 32'h0);
    checkOutput("t5b_par_dout", 32'(xor_dout), 32'h0A);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();

    $display("[TB] test 6: soft_reset and reset");
    applyStimulus(1'b1, 8'h07, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_drop_err_addr", 32'(xor_err_addr), 32'h1);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0); tick();
    checkOutput("t6_sr_err_addr", 32'(xor_err_addr), 32'h0);
    checkOutput("t6_sr_dest_valid0", 32'(xor_dest_valid), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_pre_dout", 32'(xor_dout), 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b1, 1'b0); tick();
    checkOutput("t6_sr_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t6_sr_dout", 32'(xor_dout), 32'h00);
    checkOutput("t6_sr_dest", 32'(xor_dest), 32'h0);
    checkOutput("t6_sr_dest_valid", 32'(xor_dest_valid), 32'h0);
    checkOutput("t6_sr_errs", 32'({xor_err_parity, xor_err_len, xor_err_addr}), 32'h0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_ignore0_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t6_ignore0_dest_valid", 32'(xor_dest_valid), 32'h0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_ignore1_dv", 32'(xor_dout_valid), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_resume_dv", 32'(xor_dout_valid), 32'h1);
    checkOutput("t6_resume_dout", 32'(xor_dout), 32'h0D);
    checkOutput("t6_resume_dest_valid", 32'(xor_dest_valid), 32'h1);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); tick();
    checkOutput("t6_rst_dout", 32'(xor_dout), 32'h00);
    checkOutput("t6_rst_dv", 32'(xor_dout_valid), 32'h0);
    checkOutput("t6_rst_dest", 32'(xor_dest), 32'h0);
    checkOutput("t6_rst_dest_valid", 32'(xor_dest_valid), 32'h0);
    checkOutput("t6_rst_flags", 32'({xor_parity_done, xor_err_parity, xor_err_len, xor_err_addr}),
                32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0); tick();
    checkOutput("t6_after_rst_dv", 32'(xor_dout_valid), 32'h1);
    checkOutput("t6_after_rst_dest", 32'(xor_dest), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/router_pkt_reg.md
Name: router_pkt_reg

Overview:
- Parametrised packet datapath register for the router input side. It sits between the source interface and the selected output FIFO.
- Owns its own framing FSM, so no external state-decode inputs are needed. Tracks payload length from the header and computes a selectable checksum.
- Provides a one-stage output register with FIFO backpressure, and flags address, length and parity errors.
- Successor to the fixed 8-bit, XOR-only, 3-port register block.

Parameters:
- DW, 8: data byte width.
- ADDR_W, 2: destination field width, header bits [ADDR_W-1:0].
- NUM_PORTS, 3: number of valid destinations. Valid range 1..2^ADDR_W.
- CHK_MODE, 0: 0 = XOR checksum; 1 = additive checksum mod 2^DW.
- LEN_W is derived as DW-ADDR_W (payload length field, header bits [DW-1:ADDR_W]).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous packet abort (time-out from the output side).
- pkt_valid  in  1  high for header and payload bytes; low on the parity byte.
- data_in  in  DW  input byte.
- in_ready  out  1  byte accepted this cycle when in_ready=1 and the FSM is not IDLE, or when IDLE and pkt_valid=1.
- fifo_full  in  1  full flag of the selected output FIFO.
- dout  out  DW  byte to FIFO.
- dout_valid  out  1  FIFO write request.
- dest  out  ADDR_W  latched destination.
- dest_valid  out  1  high from header accept through parity accept.
- parity_done  out  1  one-cycle pulse, parity byte accepted.
- err_parity  out  1  sticky checksum mismatch.
- err_len  out  1  sticky length mismatch.
- err_addr  out  1  sticky bad destination.

Behaviour:
Reset and abort
- reset (highest priority): FSM=IDLE; dout=0; dout_valid=0; dest=0; dest_valid=0; parity_done=0; all err_*=0; checksum=0; count=0.
- soft_reset (below reset): same clears in the next cycle. In-flight dout_valid is dropped. Remaining input bytes are ignored until pkt_valid is low for at least one cycle in IDLE.

Handshake
- in_ready = !(dout_valid && fifo_full), combinational.
- A FIFO write completes on a cycle with dout_valid=1 and fifo_full=0.
- While fifo_full=1, dout and dout_valid hold; no byte is lost or duplicated.
- Accepted byte appears on dout with dout_valid=1 the next cycle (latency 1).
- dout_valid drops after the write if no new byte was accepted.

FSM: IDLE, PAYLOAD, DROP
- IDLE, pkt_valid=1: accept header; dest <= data_in[ADDR_W-1:0]; len <= data_in[DW-1:ADDR_W]; count <= 0; checksum <= data_in; err_* <= 0; dest_valid <= 1.
  - If dest < NUM_PORTS: go to PAYLOAD and forward the header.
  - Else: err_addr <= 1; go to DROP; no dout_valid.
- PAYLOAD, accepted byte, count < len and pkt_valid=1: payload byte; forward it; count++; checksum updated (XOR, or add with carry discarded).
- PAYLOAD, accepted byte, pkt_valid=0 or count == len: parity byte.
  - Forward it.
  - err_parity <= (data_in != checksum).
  - err_len <= (count != len) || pkt_valid.
  - parity_done pulses; dest_valid <= 0; go to IDLE.
- DROP: consume bytes with in_ready forced 1 and no writes. The terminating byte is determined as in PAYLOAD. parity_done pulses; errors other than err_addr are not evaluated; go to IDLE.
- len=0: the byte after the header is parity.
- Back-to-back packets: a header is accepted in the cycle immediately after parity; errors clear on that header.
- pkt_valid=0 in IDLE: nothing accepted; outputs hold.

Test Plan:
1. DW=8, CHK_MODE=0. Header 0x0D (len 3, dest 1), payload 0x11 0x22 0x33, parity 0x0D, fifo_full=0 -> five writes 0x0D,0x11,0x22,0x33,0x0D, each 1 cycle after input; dest=1; parity_done pulse; err_*=0.
2. CHK_MODE=1, same packet with parity 0x73 -> err_parity=0. Parity 0x74 -> err_parity=1, held until the next header.
3. Test 1 with fifo_full=1 for 2 cycles while dout=0x22 -> dout holds 0x22, in_ready=0 for 2 cycles, 0x33 accepted afterwards, exactly five writes.
4. Header 0x07 (dest 3, NUM_PORTS=3), 1 payload byte, parity -> err_addr=1; zero dout_valid; parity_done pulses; next packet is accepted normally.
5. Header 0x09 (len 2), pkt_valid drops after 1 payload byte -> err_len=1; 3 writes. Separately, pkt_valid still high after 2 payload bytes -> err_len=1; that byte is treated as parity.
6. soft_reset during payload with fifo_full=1 -> next cycle dout_valid=0, FSM IDLE, errors 0. reset mid-packet -> all outputs 0.
